// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - writeback arbiter and busy scoreboard for the integer register file
//
// Merges single-cycle ALU results with handshaked long-latency results into one
// registered register-file write per cycle, tracks registers awaiting a long
// result, and exposes a bypass of the write the register file commits next edge.
//
// Ports:
//   clk, reset                 clock (rising edge), synchronous active-high reset
//   alu_valid/alu_rd/alu_data  ALU result, no backpressure
//   alu_hold                   pipeline must not present an ALU result this cycle
//   lr_valid/lr_ready/lr_rd/lr_data  long-result handshake into the buffer
//   iss_valid/iss_long/iss_rd  issue notification that marks a register busy
//   q_rs1/q_rs2/q_rd           decode hazard query addresses
//   hz_stall                   any queried register (x0 excluded) is busy
//   fwd1_hit/fwd2_hit/fwd_data bypass of the registered write for rs1/rs2
//   rf_we/rf_waddr/rf_wdata    registered register-file write port
module wb_arbiter #(
  parameter int XLEN       = 32,
  parameter int NREG       = 32,
  parameter int AW         = 5,
  parameter int LQ_DEPTH   = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_hold,
  input  logic            lr_valid,
  output logic            lr_ready,
  input  logic [AW-1:0]   lr_rd,
  input  logic [XLEN-1:0] lr_data,
  input  logic            iss_valid,
  input  logic            iss_long,
  input  logic [AW-1:0]   iss_rd,
  input  logic [AW-1:0]   q_rs1,
  input  logic [AW-1:0]   q_rs2,
  input  logic [AW-1:0]   q_rd,
  output logic            hz_stall,
  output logic            fwd1_hit,
  output logic            fwd2_hit,
  output logic [XLEN-1:0] fwd_data,
  output logic            rf_we,
  output logic [AW-1:0]   rf_waddr,
  output logic [XLEN-1:0] rf_wdata
);

  localparam int PW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int CW = $clog2(LQ_DEPTH + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [AW-1:0]   lq_rd   [LQ_DEPTH];
  logic [XLEN-1:0] lq_data [LQ_DEPTH];
  logic [PW-1:0]   head, tail;
  logic [CW-1:0]   count, count_next;
  logic [SW-1:0]   starve, starve_next;
  logic [NREG-1:0] busy, busy_next;
  logic            hold_next;

  logic            q_empty, push, pop, sel_alu;
  logic [AW-1:0]   head_rd;
  logic [XLEN-1:0] head_data;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(LQ_DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  assign q_empty   = (count == '0);
  assign push      = lr_valid && lr_ready;
  assign head_rd   = lq_rd[head];
  assign head_data = lq_data[head];
  // During a hold cycle the ALU input is ignored so the starved head always drains.
  assign sel_alu   = alu_valid && (alu_rd != '0) && !alu_hold;
  assign pop       = !sel_alu && !q_empty;

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + CW'(1);
    else if (pop && !push) count_next = count - CW'(1);
  end

  // Only losses with something buffered count; any pop restarts the window.
  always_comb begin
    starve_next = starve;
    hold_next   = 1'b0;
    if (pop) begin
      starve_next = '0;
    end else if (sel_alu && !q_empty) begin
      starve_next = starve + SW'(1);
      hold_next   = (starve == SW'(STARVE_MAX - 1));
    end
  end

  // Clear then set, so an issue to the same register in the draining cycle stays busy.
  always_comb begin
    busy_next = busy;
    if (pop) busy_next[head_rd] = 1'b0;
    if (iss_valid && iss_long && (iss_rd != '0)) busy_next[iss_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      lq_rd[tail]   <= lr_rd;
      lq_data[tail] <= lr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      starve   <= '0;
      busy     <= '0;
      alu_hold <= 1'b0;
      lr_ready <= 1'b0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      if (push) tail <= ptr_inc(tail);
      if (pop)  head <= ptr_inc(head);
      count    <= count_next;
      starve   <= starve_next;
      busy     <= busy_next;
      alu_hold <= hold_next;
      lr_ready <= (count_next < CW'(LQ_DEPTH));
      // A popped rd==0 entry is discarded without a write.
      rf_we    <= sel_alu || (pop && (head_rd != '0));
      if (sel_alu) begin
        rf_waddr <= alu_rd;
        rf_wdata <= alu_data;
      end else if (pop) begin
        rf_waddr <= head_rd;
        rf_wdata <= head_data;
      end
    end
  end

  assign hz_stall = ((q_rs1 != '0) && busy[q_rs1]) ||
                    ((q_rs2 != '0) && busy[q_rs2]) ||
                    ((q_rd  != '0) && busy[q_rd]);
  assign fwd1_hit = rf_we && (rf_waddr == q_rs1) && (q_rs1 != '0);
  assign fwd2_hit = rf_we && (rf_waddr == q_rs2) && (q_rs2 != '0);
  assign fwd_data = rf_wdata;

endmodule
